// File: rtl/alu_pkg.sv
// Shared ALU encodings and RV32I opcode/funct7 constants used by the decoder and the ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // alt selects SUB/SRA on the funct3 codes that have an alternate form
    function automatic alu_op_t op_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 32x32 integer register file: two async read ports, one write port, x0 hardwired, write-through bypass.
module reg_file #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A same-cycle write to the address being read is forwarded so the reader never sees stale data
    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (wr_en && (wr_addr == rs1_addr)) rs1_data = wr_data;
        if (wr_en && (wr_addr == rs2_addr)) rs2_data = wr_data;
        if (rs1_addr == 5'd0) rs1_data = '0;
        if (rs2_addr == 5'd0) rs2_data = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode/operand-fetch stage: decodes OP, OP-IMM and LUI, reads operands and holds the
// result in a single valid/ready output slot for the ALU.
module decode_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] src1,
    output logic [XLEN-1:0] src2,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    reg_file #(.XLEN(XLEN)) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (in_instr[19:15]),
        .rs2_addr (in_instr[24:20]),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .wr_en    (wb_we),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    // ---- stage p0: combinational decode of the incoming instruction ----
    alu_op_t         op_p0;
    logic [XLEN-1:0] src1_p0, src2_p0;
    logic            illegal_p0;
    logic            rd_we_p0;

    always_comb begin
        op_p0      = ALU_ADD;
        src1_p0    = '0;
        src2_p0    = '0;
        illegal_p0 = 1'b0;
        case (opcode)
            OPC_OP: begin
                if ((funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
                    op_p0   = op_from_funct3(funct3, funct7[5]);
                    src1_p0 = rs1_val;
                    src2_p0 = rs2_val;
                end else begin
                    illegal_p0 = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Shift-immediates reuse the funct7 field, so only the two encodings below are legal
                    if ((funct7 == F7_BASE) || ((funct7 == F7_ALT) && (funct3 == 3'b101))) begin
                        op_p0   = op_from_funct3(funct3, funct7[5]);
                        src1_p0 = rs1_val;
                        src2_p0 = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                    end else begin
                        illegal_p0 = 1'b1;
                    end
                end else begin
                    op_p0   = op_from_funct3(funct3, 1'b0);
                    src1_p0 = rs1_val;
                    src2_p0 = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                end
            end
            OPC_LUI: begin
                src2_p0 = {in_instr[31:12], 12'b0};
            end
            default: illegal_p0 = 1'b1;
        endcase
    end

    assign rd_we_p0 = !illegal_p0 && (in_instr[11:7] != 5'd0);

    // ---- stage p1: output slot register and handshake ----
    logic            vld_p1;
    alu_op_t         op_p1;
    logic [XLEN-1:0] src1_p1, src2_p1;
    logic [4:0]      rd_p1;
    logic            rd_we_p1;
    logic            illegal_p1;
    logic            take;

    assign in_ready = !vld_p1 || out_ready;
    assign take     = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            op_p1      <= ALU_ADD;
            src1_p1    <= '0;
            src2_p1    <= '0;
            rd_p1      <= '0;
            rd_we_p1   <= 1'b0;
            illegal_p1 <= 1'b0;
        end else begin
            if (flush)          vld_p1 <= 1'b0;
            else if (take)      vld_p1 <= 1'b1;
            else if (out_ready) vld_p1 <= 1'b0;
            if (take) begin
                op_p1      <= op_p0;
                src1_p1    <= src1_p0;
                src2_p1    <= src2_p0;
                rd_p1      <= in_instr[11:7];
                rd_we_p1   <= rd_we_p0;
                illegal_p1 <= illegal_p0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign alu_op    = op_p1;
    assign src1      = src1_p1;
    assign src2      = src2_p1;
    assign rd        = rd_p1;
    assign rd_we     = rd_we_p1;
    assign illegal   = illegal_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a behavioural decoder/register-file model predicts each accepted instruction.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  alu_op;
    logic [31:0] src1, src2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .src1(src1), .src2(src2), .rd(rd), .rd_we(rd_we),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sbq[$];
    exp_t held;
    logic [31:0] mreg [32];
    bit   m_vld = 0;
    bit   m_take = 0;
    bit   new_out = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && wb_rd == a) return wb_data;
        return mreg[a];
    endfunction

    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            3'd0: return 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd3;
            3'd3: return 4'd4;
            3'd4: return 4'd5;
            3'd5: return 4'd6;
            3'd6: return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic exp_t predict(input logic [31:0] ins);
        exp_t e;
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = ins[31:25];
        f3 = ins[14:12];
        e.op = 4'd0; e.s1 = 32'd0; e.s2 = 32'd0; e.rd = ins[11:7]; e.ill = 1'b1;
        if (ins[6:0] == 7'h33) begin
            if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                e.ill = 1'b0;
                e.op  = base_op(f3) + ((f7 == 7'h20) ? 4'd1 : 4'd0);
                e.s1  = mread(ins[19:15]);
                e.s2  = mread(ins[24:20]);
            end
        end else if (ins[6:0] == 7'h13) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                if (f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20)) begin
                    e.ill = 1'b0;
                    e.op  = base_op(f3) + ((f7 == 7'h20) ? 4'd1 : 4'd0);
                    e.s1  = mread(ins[19:15]);
                    e.s2  = {27'd0, ins[24:20]};
                end
            end else begin
                e.ill = 1'b0;
                e.op  = base_op(f3);
                e.s1  = mread(ins[19:15]);
                e.s2  = {{20{ins[31]}}, ins[31:20]};
            end
        end else if (ins[6:0] == 7'h37) begin
            e.ill = 1'b0;
            e.s2  = {ins[31:12], 12'h000};
        end
        e.we = !e.ill && (ins[11:7] != 5'd0);
        return e;
    endfunction

    // Reference handshake, slot and register-file model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld = 0; m_take = 0; new_out = 0;
            sbq.delete();
            for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        end else begin
            m_take = in_valid && (!m_vld || out_ready) && !flush;
            if (m_take) sbq.push_back(predict(in_instr));
            if (flush) m_vld = 0;
            else if (m_take) m_vld = 1;
            else if (out_ready) m_vld = 0;
            new_out = m_take;
            if (wb_we && wb_rd != 5'd0) mreg[wb_rd] = wb_data;
        end
    end

    task automatic cmp_slot(input string p, input exp_t e);
        check({p, "_alu_op"}, 32'(alu_op), 32'(e.op));
        check({p, "_src1"}, src1, e.s1);
        check({p, "_src2"}, src2, e.s2);
        check({p, "_rd_we"}, 32'(rd_we), 32'(e.we));
        check({p, "_illegal"}, 32'(illegal), 32'(e.ill));
        if (!e.ill) check({p, "_rd"}, 32'(rd), 32'(e.rd));
    endtask

    // Monitor: pop on each new slot, otherwise require the held slot to stay stable
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", 32'(in_ready), 32'(!m_vld || out_ready));
            check("out_valid", 32'(out_valid), 32'(m_vld));
            if (new_out) begin
                check("sbq_nonempty", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    held = sbq.pop_front();
                    cmp_slot("slot", held);
                end
                new_out = 0;
            end else if (m_vld) begin
                cmp_slot("stable", held);
            end
        end
    end

    task automatic send(input logic [31:0] ins, input bit rnd);
        bit done;
        logic [31:0] r;
        done = 0;
        in_valid = 1'b1;
        in_instr = ins;
        for (int k = 0; k < 64 && !done; k++) begin
            @(posedge clk); #1;
            done = m_take;
            if (rnd) begin
                out_ready = ($urandom_range(0, 3) != 0);
                r = $urandom();
                wb_we = r[31];
                wb_rd = r[4:0];
                wb_data = $urandom();
            end
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_rd = a; wb_data = d;
        @(posedge clk); #1;
        wb_we = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 4))
            0: return {(r[31] ? 7'h20 : r[30:24]), r[24:7], 7'h33};
            1: return {r[31:7], 7'h13};
            2: return {r[31:7], 7'h37};
            3: return r;
            default: return {7'h00, r[24:7], 7'h33};
        endcase
    endfunction

    initial begin
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_src1", src1, 32'd0);
        check("rst_src2", src2, 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_rd_we", 32'(rd_we), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd7);
        send(32'h002081B3, 0);
        @(negedge clk);
        check("add_alu_op", 32'(alu_op), 32'h0);
        check("add_src1", src1, 32'd5);
        check("add_src2", src2, 32'd7);
        check("add_rd", 32'(rd), 32'd3);
        check("add_rd_we", 32'(rd_we), 32'd1);

        send(32'hFFF00093, 0);
        @(negedge clk);
        check("addi_src1", src1, 32'd0);
        check("addi_src2", src2, 32'hFFFFFFFF);
        send(32'h40335293, 0);
        @(negedge clk);
        check("srai_alu_op", 32'(alu_op), 32'h7);
        check("srai_src2", src2, 32'd3);
        send(32'hABCDE3B7, 0);
        @(negedge clk);
        check("lui_src2", src2, 32'hABCDE000);
        check("lui_rd", 32'(rd), 32'd7);

        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234;
        send(32'h002081B3, 0);
        wb_we = 1'b0;
        @(negedge clk);
        check("bypass_src1", src1, 32'h1234);
        wb_write(5'd0, 32'hDEAD);
        send(32'h002001B3, 0);
        @(negedge clk);
        check("x0_src1", src1, 32'd0);

        send(32'h402081B3, 0);
        send(32'h402091B3, 0);
        send(32'h40209093, 0);
        send(32'h0000006F, 0);
        @(negedge clk);
        check("jal_illegal", 32'(illegal), 32'd1);
        check("jal_rd_we", 32'(rd_we), 32'd0);
        send(32'h000000EF, 0);
        @(negedge clk);
        check("jal1_rd_we", 32'(rd_we), 32'd0);

        // Backpressure then release: one transfer per cycle
        send(32'h00310233, 0);
        in_valid = 1'b1; in_instr = 32'h00418333; out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_instr = 32'h00520433;
        @(posedge clk); #1;
        in_instr = 32'h00628533;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);

        // Flush with a concurrent input that would otherwise be taken
        send(32'h00730633, 0);
        in_valid = 1'b1; in_instr = 32'h00838733; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_dropped", 32'(sbq.size()), 32'd0);

        for (int n = 0; n < 200; n++) send(rand_instr(), 1);
        wb_we = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("sbq_drained", 32'(sbq.size()), 32'd0);

        // Asynchronous reset while a slot is held
        send(32'h002081B3, 0);
        out_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_alu_op", 32'(alu_op), 32'd0);
        check("arst_src1", src1, 32'd0);
        check("arst_src2", src2, 32'd0);
        check("arst_rd", 32'(rd), 32'd0);
        check("arst_rd_we", 32'(rd_we), 32'd0);
        check("arst_illegal", 32'(illegal), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'h002081B3, 0);
        @(negedge clk);
        check("post_rst_src1", src1, 32'd0);
        check("post_rst_src2", src2, 32'd0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
